rv_range_counter: RTL and testbench

RV_RANGE_COUNTER -- requirements
Module: rv_range_counter

---
 rtl/rv_range_counter.sv | 175 +++++++++++++++++
 tb/tb_rv_range_counter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_range_counter.sv
// rv_range_counter
//   Streams the indices start, start+step, ... up to an inclusive limit over a
//   valid/ready output channel. A range is requested with a valid/ready start
//   handshake. It runs once, or repeats forever when AUTO_RESTART is set.
//   The range can be cancelled with abort at any time.
//
// Parameters
//   WIDTH        width of the start, limit, step and data fields
//   AUTO_RESTART 1: rerun the latched range until abort; 0: one-shot
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   go_valid   in   request to start a range
//   go_ready   out  high only while idle
//   cfg_start  in   first index            (sampled on the start handshake)
//   cfg_limit  in   inclusive upper bound  (sampled on the start handshake)
//   cfg_step   in   increment, 0 means 1   (sampled on the start handshake)
//   abort      in   synchronous cancel of the current range
//   out_valid  out  out_data holds a valid index
//   out_ready  in   downstream accepts the current index
//   out_data   out  current index
//   out_last   out  current index is the final one of this pass
//   busy       out  a range is being emitted
//   done       out  one-cycle pulse when a one-shot range ends
//
// All outputs are registers or are decoded from the state register only. No
// output depends combinationally on out_ready or go_valid.

module rv_range_counter #(
    parameter int WIDTH        = 8,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go_valid,
    output logic             go_ready,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic [WIDTH-1:0] cfg_step,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;

    logic             start_hs;
    logic             xfer;
    logic [WIDTH-1:0] next_idx;

    // A stored step of zero behaves as a step of one.
    function automatic logic [WIDTH-1:0] eff_step(input logic [WIDTH-1:0] s);
        return (s == '0) ? WIDTH'(1) : s;
    endfunction

    // Decide whether index v is the final one of a pass. The successor is
    // formed one bit wider, so a carry out of WIDTH bits also exceeds the
    // limit. A pass therefore ends before it can wrap below start.
    function automatic logic is_last(input logic [WIDTH-1:0] v,
                                     input logic [WIDTH-1:0] lim,
                                     input logic [WIDTH-1:0] stp);
        logic [WIDTH:0] sum;
        sum = {1'b0, v} + {1'b0, eff_step(stp)};
        return sum > {1'b0, lim};
    endfunction

    // abort in IDLE blocks a simultaneous start request.
    // abort in RUN wins over a simultaneous transfer.
    assign start_hs = (state == IDLE) && go_valid && !abort;
    assign xfer     = (state == RUN) && out_ready && !abort;

    // This value is only loaded when last_q is clear. In that case the
    // successor is known not to overflow, so a WIDTH-bit sum is enough.
    assign next_idx = data_q + eff_step(step_q);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments. All
    // registers then sample pre-edge values, whatever the process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_next receives a default before the case statement. No path
    // then leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_hs) begin
                    state_next = (cfg_start > cfg_limit) ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (out_ready && last_q && !AUTO_RESTART) begin
                    state_next = FLUSH;
                end
            end
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from the state register
    // ------------------------------------------------------------------
    // FLUSH lasts exactly one cycle, and that cycle is the done pulse.
    always_comb begin
        go_ready  = (state == IDLE);
        out_valid = (state == RUN);
        busy      = (state == RUN);
        done      = (state == FLUSH);
        out_last  = last_q && (state == RUN);
        out_data  = data_q;
    end

    // ------------------------------------------------------------------
    // Range registers and index datapath
    // ------------------------------------------------------------------
    // NOTE: the latched range is reset as well as the index. A reset then
    // leaves no trace of a discarded range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
            limit_q <= '0;
            step_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (start_hs) begin
            start_q <= cfg_start;
            limit_q <= cfg_limit;
            step_q  <= cfg_step;
            data_q  <= cfg_start;
            last_q  <= is_last(cfg_start, cfg_limit, cfg_step);
        end else if (xfer) begin
            if (!last_q) begin
                data_q <= next_idx;
                last_q <= is_last(next_idx, limit_q, step_q);
            end else if (AUTO_RESTART) begin
                // Go straight back to start with no idle cycle in between.
                data_q <= start_q;
                last_q <= is_last(start_q, limit_q, step_q);
            end
        end
    end

endmodule

// File: tb/tb_rv_range_counter.sv
`timescale 1ns/1ps
// Bench for rv_range_counter.
//   dut  : WIDTH=8, one-shot. Checked every cycle against a queue-based model
//          and by directed literal sequences.
//   ar   : WIDTH=8, AUTO_RESTART=1. Directed sequence checks.
//   w2   : WIDTH=2, one-shot. Directed sequence checks.
module tb_rv_range_counter;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance ----------------
    logic         go_valid, go_ready, abort, out_valid, out_ready, out_last, busy, done;
    logic [W-1:0] cfg_start, cfg_limit, cfg_step, out_data;

    rv_range_counter #(.WIDTH(W), .AUTO_RESTART(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .go_valid(go_valid), .go_ready(go_ready),
        .cfg_start(cfg_start), .cfg_limit(cfg_limit), .cfg_step(cfg_step),
        .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    // ---------------- auto-restart instance ----------------
    logic         ar_go_valid, ar_go_ready, ar_abort, ar_out_valid, ar_out_ready;
    logic         ar_out_last, ar_busy, ar_done;
    logic [W-1:0] ar_cfg_start, ar_cfg_limit, ar_cfg_step, ar_out_data;

    rv_range_counter #(.WIDTH(W), .AUTO_RESTART(1'b1)) ar_dut (
        .clk(clk), .rst_n(rst_n),
        .go_valid(ar_go_valid), .go_ready(ar_go_ready),
        .cfg_start(ar_cfg_start), .cfg_limit(ar_cfg_limit), .cfg_step(ar_cfg_step),
        .abort(ar_abort),
        .out_valid(ar_out_valid), .out_ready(ar_out_ready),
        .out_data(ar_out_data), .out_last(ar_out_last),
        .busy(ar_busy), .done(ar_done)
    );

    // ---------------- 2-bit instance ----------------
    logic       w2_go_valid, w2_go_ready, w2_abort, w2_out_valid, w2_out_ready;
    logic       w2_out_last, w2_busy, w2_done;
    logic [1:0] w2_cfg_start, w2_cfg_limit, w2_cfg_step, w2_out_data;

    rv_range_counter #(.WIDTH(2), .AUTO_RESTART(1'b0)) w2_dut (
        .clk(clk), .rst_n(rst_n),
        .go_valid(w2_go_valid), .go_ready(w2_go_ready),
        .cfg_start(w2_cfg_start), .cfg_limit(w2_cfg_limit), .cfg_step(w2_cfg_step),
        .abort(w2_abort),
        .out_valid(w2_out_valid), .out_ready(w2_out_ready),
        .out_data(w2_out_data), .out_last(w2_out_last),
        .busy(w2_busy), .done(w2_done)
    );

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the main instance ----------------
    // m_st: 0 idle, 1 emitting, 2 done cycle.
    // m_q holds the indices of the pass that remain to be emitted.
    int m_st = 0;
    int m_q[$];
    int xfer_cnt = 0;
    int exp_cnt  = 0;
    int seen_data[$];
    int seen_last[$];
    int done_cnt = 0;

    function automatic int eff(input int s);
        return (s == 0) ? 1 : s;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_st = 0;
            m_q.delete();
        end

        check("go_ready", go_ready, m_st == 0);
        check("out_valid", out_valid, m_st == 1);
        check("busy", busy, m_st == 1);
        check("done", done, m_st == 2);
        if (m_st == 1 && m_q.size() > 0) begin
            check("out_data", out_data, m_q[0]);
            check("out_last", out_last, m_q.size() == 1);
        end

        if (out_valid && out_ready) begin
            seen_data.push_back(int'(out_data));
            seen_last.push_back(int'(out_last));
            xfer_cnt++;
        end
        if (done) done_cnt++;

        if (rst_n) begin
            case (m_st)
                0: if (go_valid && !abort) begin
                    m_q.delete();
                    for (int v = int'(cfg_start); v <= int'(cfg_limit); v += eff(int'(cfg_step)))
                        m_q.push_back(v);
                    m_st     = (m_q.size() == 0) ? 2 : 1;
                    xfer_cnt = 0;
                    exp_cnt  = (cfg_start > cfg_limit) ? 0 :
                               (int'(cfg_limit) - int'(cfg_start)) / eff(int'(cfg_step)) + 1;
                end
                1: if (abort) begin
                    m_st = 0;
                    m_q.delete();
                end else if (out_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_st = 2;
                        check("count", xfer_cnt, exp_cnt);
                    end
                end
                default: m_st = 0;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    int exp_seq[8];
    int exp_n;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input bit rnd_ready);
        for (int i = 0; i < budget; i++) begin
            if (go_ready) return;
            if (rnd_ready) out_ready = ($urandom % 2) == 0;
            tick();
        end
        check("idle_timeout", 0, 1);
    endtask

    task automatic run_range(input int s, input int l, input int st, input bit rnd_ready);
        seen_data.delete();
        seen_last.delete();
        done_cnt  = 0;
        cfg_start = W'(s);
        cfg_limit = W'(l);
        cfg_step  = W'(st);
        go_valid  = 1'b1;
        tick();
        go_valid  = 1'b0;
        cfg_start = W'($urandom);
        cfg_limit = W'($urandom);
        cfg_step  = W'($urandom);
        wait_idle(1000, rnd_ready);
        out_ready = 1'b1;
    endtask

    task automatic check_seq(input string nm);
        check({nm, "_len"}, seen_data.size(), exp_n);
        for (int i = 0; i < exp_n; i++) begin
            check({nm, "_data"}, (i < seen_data.size()) ? seen_data[i] : -1, exp_seq[i]);
            check({nm, "_last"}, (i < seen_last.size()) ? seen_last[i] : -1, i == exp_n - 1);
        end
        check({nm, "_done"}, done_cnt, 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        go_valid = 0; abort = 0; out_ready = 1;
        cfg_start = 0; cfg_limit = 0; cfg_step = 0;
        ar_go_valid = 0; ar_abort = 0; ar_out_ready = 1;
        ar_cfg_start = 0; ar_cfg_limit = 0; ar_cfg_step = 0;
        w2_go_valid = 0; w2_abort = 0; w2_out_ready = 1;
        w2_cfg_start = 0; w2_cfg_limit = 0; w2_cfg_step = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_go_ready", go_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        // 2-bit full range 0..3
        w2_cfg_start = 2'd0; w2_cfg_limit = 2'd3; w2_cfg_step = 2'd1;
        w2_go_valid = 1'b1;
        tick();
        w2_go_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("w2_data", w2_out_data, i);
            check("w2_valid", w2_out_valid, 1);
            check("w2_last", w2_out_last, i == 3);
            check("w2_done_run", w2_done, 0);
            tick();
        end
        check("w2_done", w2_done, 1);
        check("w2_valid_flush", w2_out_valid, 0);
        check("w2_go_ready_flush", w2_go_ready, 0);
        tick();
        check("w2_done_after", w2_done, 0);
        check("w2_go_ready_back", w2_go_ready, 1);

        // auto-restart 1..3, then abort
        ar_cfg_start = 8'd1; ar_cfg_limit = 8'd3; ar_cfg_step = 8'd1;
        ar_go_valid = 1'b1;
        tick();
        ar_go_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("ar_data", ar_out_data, 1 + (i % 3));
            check("ar_last", ar_out_last, (i % 3) == 2);
            check("ar_valid", ar_out_valid, 1);
            check("ar_done", ar_done, 0);
            tick();
        end
        ar_abort = 1'b1;
        tick();
        ar_abort = 1'b0;
        check("ar_abort_valid", ar_out_valid, 0);
        check("ar_abort_go_ready", ar_go_ready, 1);
        check("ar_abort_done", ar_done, 0);
        tick();
        check("ar_abort_done2", ar_done, 0);
        // abort in IDLE blocks a simultaneous start request
        ar_abort = 1'b1; ar_go_valid = 1'b1;
        tick();
        ar_abort = 1'b0; ar_go_valid = 1'b0;
        check("ar_idle_abort_busy", ar_busy, 0);
        check("ar_idle_abort_ready", ar_go_ready, 1);

        // main instance: directed literal ranges
        run_range(250, 255, 4, 1'b0);
        exp_seq = '{250, 254, 0, 0, 0, 0, 0, 0}; exp_n = 2;
        check_seq("ovf");
        run_range(5, 5, 7, 1'b0);
        exp_seq = '{5, 0, 0, 0, 0, 0, 0, 0}; exp_n = 1;
        check_seq("single");
        run_range(0, 2, 0, 1'b0);
        exp_seq = '{0, 1, 2, 0, 0, 0, 0, 0}; exp_n = 3;
        check_seq("step0");
        run_range(9, 3, 1, 1'b0);
        exp_n = 0;
        check_seq("empty");
        run_range(10, 100, 7, 1'b1);
        check("bp_len", seen_data.size(), 13);
        check("bp_final", (seen_data.size() == 13) ? seen_data[12] : -1, 94);

        // empty range: done comes in the cycle after the handshake
        cfg_start = 8'd9; cfg_limit = 8'd3; cfg_step = 8'd1;
        go_valid = 1'b1;
        tick();
        go_valid = 1'b0;
        check("empty_done", done, 1);
        check("empty_valid", out_valid, 0);
        tick();
        check("empty_done_off", done, 0);
        check("empty_ready", go_ready, 1);

        // go_valid held through a range: the new cfg is taken only once idle
        seen_data.delete(); seen_last.delete(); done_cnt = 0;
        cfg_start = 8'd0; cfg_limit = 8'd20; cfg_step = 8'd5;
        go_valid = 1'b1;
        tick();
        cfg_start = 8'd100; cfg_limit = 8'd102; cfg_step = 8'd1;
        for (int i = 0; i < 40 && seen_data.size() < 8; i++) tick();
        go_valid = 1'b0;
        wait_idle(100, 1'b0);
        exp_seq = '{0, 5, 10, 15, 20, 100, 101, 102};
        check("hold_len", seen_data.size(), 8);
        for (int i = 0; i < 8; i++)
            check("hold_data", (i < seen_data.size()) ? seen_data[i] : -1, exp_seq[i]);
        check("hold_done", done_cnt, 2);

        // reset in the middle of a range, then start on the first edge after release
        cfg_start = 8'd0; cfg_limit = 8'd200; cfg_step = 8'd1;
        go_valid = 1'b1;
        tick();
        go_valid = 1'b0;
        repeat (5) tick();
        done_cnt = 0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", go_ready, 1);
        check("mid_rst_done", done, 0);
        tick();
        rst_n = 1'b1;
        cfg_start = 8'd3; cfg_limit = 8'd4; cfg_step = 8'd1;
        go_valid = 1'b1;
        tick();
        go_valid = 1'b0;
        check("post_rst_busy", busy, 1);
        check("post_rst_data", out_data, 3);
        wait_idle(50, 1'b0);
        check("post_rst_done", done_cnt, 1);

        // randomized traffic checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom % 3) != 0;
            abort     = ($urandom % 50) == 0;
            go_valid  = ($urandom % 3) == 0;
            cfg_start = W'($urandom);
            cfg_limit = (($urandom % 4) == 0) ? W'($urandom) : W'(cfg_start + W'($urandom % 40));
            cfg_step  = (($urandom % 4) == 0) ? W'($urandom) : W'($urandom % 6);
            tick();
        end
        abort = 1'b0; go_valid = 1'b0; out_ready = 1'b1;
        wait_idle(600, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
